// File: rtl/axil_lbs_bridge.sv
// AXI4-Lite slave that turns register accesses into single-cycle local-bus strobes.
// One transaction in flight, fair read/write arbitration, and DECERR outside the address window.
module axil_lbs_bridge #(
  parameter int unsigned U_DLY      = 1,
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_FFFF,
  parameter int unsigned LBS_AW     = 16,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [31:0]       araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic [LBS_AW-1:0] lbs_addr,
  output logic [31:0]       lbs_din,
  output logic [3:0]        lbs_be,
  output logic              lbs_we,
  output logic              lbs_re,
  input  logic [31:0]       lbs_dout
);

  // U_DLY is kept only so existing instantiations still elaborate; the flops carry no delay.
  if (RD_LAT > 15 || LBS_AW < 1 || LBS_AW > 30 || U_DLY > 1000) begin : g_bad_param
    $error("axil_lbs_bridge: parameter out of range");
  end

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WSTB,
    WRSP,
    RSTB,
    RWAIT,
    RRSP
  } state_e;

  typedef enum logic {
    PRIO_W,
    PRIO_R
  } prio_e;

  state_e            state_q, state_d;
  prio_e             prio_q, prio_d;
  logic              hit_q, hit_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [LBS_AW-1:0] lbs_addr_q, lbs_addr_d;
  logic [31:0]       lbs_din_q, lbs_din_d;
  logic [3:0]        lbs_be_q, lbs_be_d;
  logic              lbs_we_q, lbs_we_d;
  logic              lbs_re_q, lbs_re_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;

  logic idle;
  logic w_elig;
  logic grant_w;
  logic grant_r;

  // Window check works on word indices so the byte offset within a word never matters.
  function automatic logic in_window(input logic [29:0] word);
    return (word >= C_BASEADDR[31:2]) && (word <= C_HIGHADDR[31:2]);
  endfunction

  function automatic logic [LBS_AW-1:0] lbs_word(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - C_BASEADDR;
    return LBS_AW'(off >> 2);
  endfunction

  assign idle    = (state_q == IDLE) && !rst;
  assign w_elig  = awvalid && wvalid;
  assign grant_w = idle && w_elig && (!arvalid || prio_q == PRIO_W);
  assign grant_r = idle && arvalid && (!w_elig || prio_q == PRIO_R);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    hit_d      = hit_q;
    cnt_d      = cnt_q;
    lbs_addr_d = lbs_addr_q;
    lbs_din_d  = lbs_din_q;
    lbs_be_d   = lbs_be_q;
    lbs_we_d   = 1'b0;
    lbs_re_d   = 1'b0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_w) begin
          state_d = WSTB;
          prio_d  = PRIO_R;
          hit_d   = in_window(awaddr[31:2]);
          if (in_window(awaddr[31:2])) begin
            lbs_addr_d = lbs_word(awaddr);
            lbs_din_d  = wdata;
            lbs_be_d   = wstrb;
            lbs_we_d   = 1'b1;
          end
        end else if (grant_r) begin
          state_d = RSTB;
          prio_d  = PRIO_W;
          hit_d   = in_window(araddr[31:2]);
          if (in_window(araddr[31:2])) begin
            lbs_addr_d = lbs_word(araddr);
            lbs_re_d   = 1'b1;
          end
        end
      end

      WSTB: begin
        state_d  = WRSP;
        bvalid_d = 1'b1;
        bresp_d  = hit_q ? RESP_OKAY : RESP_DECERR;
      end

      WRSP: begin
        if (bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end

      RSTB: begin
        if (RD_LAT == 0) begin
          state_d  = RRSP;
          rvalid_d = 1'b1;
          rdata_d  = hit_q ? lbs_dout : '0;
          rresp_d  = hit_q ? RESP_OKAY : RESP_DECERR;
        end else begin
          state_d = RWAIT;
          cnt_d   = 4'(RD_LAT - 1);
        end
      end

      // Last RWAIT cycle is the one where lbs_dout is valid, so capture there.
      RWAIT: begin
        if (cnt_q == '0) begin
          state_d  = RRSP;
          rvalid_d = 1'b1;
          rdata_d  = hit_q ? lbs_dout : '0;
          rresp_d  = hit_q ? RESP_OKAY : RESP_DECERR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RRSP: begin
        if (rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= PRIO_W;
      hit_q      <= 1'b0;
      cnt_q      <= '0;
      lbs_addr_q <= '0;
      lbs_din_q  <= '0;
      lbs_be_q   <= '0;
      lbs_we_q   <= 1'b0;
      lbs_re_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      hit_q      <= hit_d;
      cnt_q      <= cnt_d;
      lbs_addr_q <= lbs_addr_d;
      lbs_din_q  <= lbs_din_d;
      lbs_be_q   <= lbs_be_d;
      lbs_we_q   <= lbs_we_d;
      lbs_re_q   <= lbs_re_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign awready  = grant_w;
  assign wready   = grant_w;
  assign arready  = grant_r;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign rvalid   = rvalid_q;
  assign rresp    = rresp_q;
  assign rdata    = rdata_q;
  assign lbs_addr = lbs_addr_q;
  assign lbs_din  = lbs_din_q;
  assign lbs_be   = lbs_be_q;
  assign lbs_we   = lbs_we_q;
  assign lbs_re   = lbs_re_q;

endmodule

// File: tb/tb_axil_lbs_bridge.sv
// Directed bench for axil_lbs_bridge: 64 KiB window at 0, 16-bit word address, RD_LAT=2.
module tb_axil_lbs_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata, lbs_din, lbs_dout;
  logic [3:0]  wstrb, lbs_be;
  logic [1:0]  bresp, rresp;
  logic [15:0] lbs_addr;
  logic        lbs_we, lbs_re;

  int vectors     = 0;
  int miscompares = 0;

  axil_lbs_bridge #(
    .U_DLY      (1),
    .C_BASEADDR (32'h0000_0000),
    .C_HIGHADDR (32'h0000_FFFF),
    .LBS_AW     (16),
    .RD_LAT     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .awvalid  (awvalid),
    .awready  (awready),
    .awaddr   (awaddr),
    .wvalid   (wvalid),
    .wready   (wready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .bvalid   (bvalid),
    .bready   (bready),
    .bresp    (bresp),
    .arvalid  (arvalid),
    .arready  (arready),
    .araddr   (araddr),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .rresp    (rresp),
    .lbs_addr (lbs_addr),
    .lbs_din  (lbs_din),
    .lbs_be   (lbs_be),
    .lbs_we   (lbs_we),
    .lbs_re   (lbs_re),
    .lbs_dout (lbs_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hs"}, {21'd0, awready, wready, arready, bvalid, rvalid, lbs_we, lbs_re, bresp, rresp}, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_addr"}, {16'd0, lbs_addr}, 32'd0);
    check({tag, "_din"}, lbs_din, 32'd0);
    check({tag, "_be"}, {28'd0, lbs_be}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_w;
    int   we_cnt, re_cnt;
    logic done;

    rst = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    lbs_dout = 32'hDEAD_BEEF;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // write hit
    awvalid = 1; wvalid = 1; awaddr = 32'h0000_0010; wdata = 32'hA5A5_0001; wstrb = 4'hF; bready = 1;
    #1;
    check("w_awready", awready, 1);
    check("w_wready", wready, 1);
    next();
    awvalid = 0; wvalid = 0;
    check("w_we", lbs_we, 1);
    check("w_addr", lbs_addr, 32'd4);
    check("w_be", lbs_be, 32'hF);
    check("w_din", lbs_din, 32'hA5A5_0001);
    check("w_bvalid_early", bvalid, 0);
    next();
    check("w_we_off", lbs_we, 0);
    check("w_bvalid", bvalid, 1);
    check("w_bresp", bresp, 0);
    next();
    check("w_bvalid_done", bvalid, 0);

    // read hit with RD_LAT=2, held off by rready=0
    arvalid = 1; araddr = 32'h0000_0008; rready = 0;
    #1;
    check("r_arready", arready, 1);
    check("r_awready", awready, 0);
    next();
    arvalid = 0;
    check("r_re", lbs_re, 1);
    check("r_addr", lbs_addr, 32'd2);
    next();
    check("r_re_off", lbs_re, 0);
    check("r_rvalid_n2", rvalid, 0);
    next();
    lbs_dout = 32'h1234_5678;
    check("r_rvalid_n3", rvalid, 0);
    next();
    lbs_dout = 32'hDEAD_BEEF;
    check("r_rvalid", rvalid, 1);
    check("r_rdata", rdata, 32'h1234_5678);
    check("r_rresp", rresp, 0);
    for (int i = 0; i < 3; i++) begin
      next();
      check("hold_rvalid", rvalid, 1);
      check("hold_rdata", rdata, 32'h1234_5678);
      check("hold_rresp", rresp, 0);
    end
    rready = 1;
    next();
    check("r_rvalid_done", rvalid, 0);

    // simultaneous requests: last served was a read, so W,R,W,R
    for (int k = 0; k < 4; k++) begin
      exp_w = (k % 2 == 0);
      awvalid = 1; wvalid = 1; arvalid = 1;
      awaddr = 32'h20 + 32'(k * 4); wdata = 32'(k); wstrb = 4'hF; araddr = 32'h40;
      #1;
      check("arb_aw", awready, {31'd0, exp_w});
      check("arb_ar", arready, {31'd0, !exp_w});
      next();
      awvalid = 0; wvalid = 0; arvalid = 0;
      we_cnt = 0; re_cnt = 0; done = 0;
      for (int c = 0; c < 12 && !done; c++) begin
        we_cnt += int'(lbs_we);
        re_cnt += int'(lbs_re);
        if (bvalid || rvalid) done = 1;
        else next();
      end
      check("arb_done", done, 1);
      check("arb_we_cnt", we_cnt, exp_w ? 1 : 0);
      check("arb_re_cnt", re_cnt, exp_w ? 0 : 1);
      next();
    end

    // read miss
    arvalid = 1; araddr = 32'h0001_0000;
    #1;
    check("rm_arready", arready, 1);
    next();
    arvalid = 0;
    check("rm_no_re", lbs_re, 0);
    check("rm_addr_kept", lbs_addr, 32'h10);
    next(); next(); next();
    check("rm_rvalid", rvalid, 1);
    check("rm_rresp", rresp, 32'h3);
    check("rm_rdata", rdata, 0);
    next();
    check("rm_rvalid_done", rvalid, 0);

    // write miss
    awvalid = 1; wvalid = 1; awaddr = 32'h0001_0000; wdata = 32'hFFFF_FFFF; wstrb = 4'h3;
    #1;
    check("wm_awready", awready, 1);
    next();
    awvalid = 0; wvalid = 0;
    check("wm_no_we", lbs_we, 0);
    check("wm_din_kept", lbs_din, 32'h2);
    check("wm_be_kept", lbs_be, 32'hF);
    next();
    check("wm_bvalid", bvalid, 1);
    check("wm_bresp", bresp, 32'h3);
    next();

    // address without data, top word of the window
    awvalid = 1; wvalid = 0; awaddr = 32'h0000_FFFC; wdata = 32'h5A5A_C3C3; wstrb = 4'h5;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("aw_only_awready", awready, 0);
      check("aw_only_wready", wready, 0);
      next();
    end
    wvalid = 1;
    #1;
    check("aw_w_awready", awready, 1);
    check("aw_w_wready", wready, 1);
    next();
    awvalid = 0; wvalid = 0;
    check("top_we", lbs_we, 1);
    check("top_addr", lbs_addr, 32'h3FFF);
    check("top_be", lbs_be, 32'h5);
    check("top_din", lbs_din, 32'h5A5A_C3C3);
    next();
    check("top_bresp", {31'd0, bvalid, bresp}, 32'h4);
    next();

    // reset during RWAIT
    arvalid = 1; araddr = 32'h0000_000C;
    #1;
    check("rr_arready", arready, 1);
    next();
    arvalid = 0;
    check("rr_re", lbs_re, 1);
    next();
    #2;
    rst = 1;
    #1;
    check_all_zero("mid_rst");
    next();
    rst = 0;
    check_all_zero("post_rst");
    for (int i = 0; i < 6; i++) begin
      next();
      check("post_rst_no_rvalid", rvalid, 0);
    end

    // fresh read after reset
    arvalid = 1; araddr = 32'h0000_0008;
    #1;
    check("nr_arready", arready, 1);
    next();
    arvalid = 0;
    check("nr_re", lbs_re, 1);
    check("nr_addr", lbs_addr, 32'd2);
    next(); next();
    lbs_dout = 32'hCAFE_F00D;
    next();
    lbs_dout = 32'hDEAD_BEEF;
    check("nr_rvalid", rvalid, 1);
    check("nr_rdata", rdata, 32'hCAFE_F00D);
    check("nr_rresp", rresp, 0);
    next();
    check("nr_rvalid_done", rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
